// File: rtl/axi_route_tracker.sv
// In-order slave-index FIFO for one AXI address/response channel pair: records the decoded
// slave on each address handshake and steers the response channel from the FIFO head.
module axi_route_tracker #(
    parameter int SlaveCount      = 7,
    parameter int SelSlaveCount   = 3,
    parameter int Depth           = 4,
    parameter int DefaultSlaveIdx = SlaveCount - 1,
    parameter int LastMode        = 1
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    input  logic [SlaveCount-1:0]          VALID_Slave,
    input  logic                           AddrHandShake,
    input  logic                           RespHandShake,
    input  logic                           RespLast,
    output logic [SelSlaveCount-1:0]       sel_AddrSlave,
    output logic [SelSlaveCount-1:0]       sel_RespSlave,
    output logic                           RespRouteValid,
    output logic                           AddrStall,
    output logic [$clog2(Depth+1)-1:0]     Outstanding,
    output logic                           OverflowErr,
    output logic                           UnderflowErr
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [SelSlaveCount-1:0] DefIdx  = SelSlaveCount'(DefaultSlaveIdx);
    localparam logic [CntW-1:0]          FullCnt = CntW'(Depth);
    localparam logic [PtrW-1:0]          LastPtr = PtrW'(Depth - 1);

    logic [SelSlaveCount-1:0] mem [Depth];
    logic [PtrW-1:0]          rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic [CntW-1:0]          cnt, cnt_nxt;
    logic [SelSlaveCount-1:0] head, head_nxt;
    logic                     empty, full, last_ok, pop_req, pop_acc, push_acc;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel_AddrSlave = DefIdx;
        if ($countones(VALID_Slave) == 1) begin
            for (int i = 0; i < SlaveCount; i++) begin
                if (VALID_Slave[i]) sel_AddrSlave = SelSlaveCount'(i);
            end
        end
    end

    assign empty    = (cnt == '0);
    assign full     = (cnt == FullCnt);
    assign last_ok  = (LastMode == 0) ? 1'b1 : RespLast;
    assign pop_req  = RespHandShake & last_ok;
    assign pop_acc  = pop_req & ~empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a paired push.
    assign push_acc = AddrHandShake & (~full | pop_acc);

    assign rd_nxt = pop_acc  ? ((rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1) : rd_ptr;
    assign wr_nxt = push_acc ? ((wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1) : wr_ptr;

    always_comb begin
        cnt_nxt = cnt;
        if (push_acc && !pop_acc)      cnt_nxt = cnt + 1'b1;
        else if (pop_acc && !push_acc) cnt_nxt = cnt - 1'b1;
    end

    // Next head: the slot being written this cycle must be forwarded, it is not in mem yet.
    always_comb begin
        head_nxt = DefIdx;
        if (cnt_nxt != '0) begin
            if (push_acc && (rd_nxt == wr_ptr)) head_nxt = sel_AddrSlave;
            else                                head_nxt = mem[rd_nxt];
        end
    end

    // NOTE: storage has no reset; an entry is only read after it has been written.
    always_ff @(posedge ACLK) begin
        if (push_acc) mem[wr_ptr] <= sel_AddrSlave;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            cnt          <= '0;
            head         <= DefIdx;
            OverflowErr  <= 1'b0;
            UnderflowErr <= 1'b0;
        end else begin
            rd_ptr <= rd_nxt;
            wr_ptr <= wr_nxt;
            cnt    <= cnt_nxt;
            head   <= head_nxt;
            if (AddrHandShake && full && !pop_acc) OverflowErr  <= 1'b1;
            if (pop_req && empty)                  UnderflowErr <= 1'b1;
        end
    end

    assign sel_RespSlave  = head;
    assign Outstanding    = cnt;
    assign RespRouteValid = ~empty;
    assign AddrStall      = full;

endmodule

// File: tb/tb_axi_route_tracker.sv
// Randomized and directed bench for axi_route_tracker: an R-channel instance (Depth 4) and a
// B-channel instance (Depth 3) share stimulus and are compared against queue-based models.
module tb_axi_route_tracker;

    logic       ACLK;
    logic       ARESETn;
    logic [6:0] valid;
    logic       addr_hs, resp_hs, resp_last;

    logic [2:0] sel_addr [2];
    logic [2:0] sel_resp [2];
    logic       route_valid [2];
    logic       stall [2];
    logic [2:0] outstanding [2];
    logic       ovf_err [2];
    logic       unf_err [2];

    int q [2][$];
    bit m_ovf [2];
    bit m_unf [2];
    int n_checks = 0;
    int n_errors = 0;

    axi_route_tracker #(.Depth(4), .LastMode(1)) u_dut_r (
        .ACLK(ACLK), .ARESETn(ARESETn), .VALID_Slave(valid), .AddrHandShake(addr_hs),
        .RespHandShake(resp_hs), .RespLast(resp_last), .sel_AddrSlave(sel_addr[0]),
        .sel_RespSlave(sel_resp[0]), .RespRouteValid(route_valid[0]), .AddrStall(stall[0]),
        .Outstanding(outstanding[0]), .OverflowErr(ovf_err[0]), .UnderflowErr(unf_err[0])
    );

    axi_route_tracker #(.Depth(3), .LastMode(0)) u_dut_b (
        .ACLK(ACLK), .ARESETn(ARESETn), .VALID_Slave(valid), .AddrHandShake(addr_hs),
        .RespHandShake(resp_hs), .RespLast(resp_last), .sel_AddrSlave(sel_addr[1]),
        .sel_RespSlave(sel_resp[1]), .RespRouteValid(route_valid[1]), .AddrStall(stall[1]),
        .Outstanding(outstanding[1]), .OverflowErr(ovf_err[1]), .UnderflowErr(unf_err[1])
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    function automatic int depth_of(int m);
        return (m == 0) ? 4 : 3;
    endfunction

    function automatic bit last_mode_of(int m);
        return (m == 0);
    endfunction

    function automatic int decode(logic [6:0] v);
        if ($countones(v) == 1) return $clog2(v);
        return 6;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            q[m].delete();
            m_ovf[m] = 1'b0;
            m_unf[m] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit pc;
        for (int m = 0; m < 2; m++) begin
            pc = resp_hs && (resp_last || !last_mode_of(m));
            if (pc) begin
                if (q[m].size() == 0) m_unf[m] = 1'b1;
                else void'(q[m].pop_front());
            end
            if (addr_hs) begin
                if (q[m].size() >= depth_of(m)) m_ovf[m] = 1'b1;
                else q[m].push_back(decode(valid));
            end
        end
    endtask

    task automatic check_outputs(input string ph);
        int sz;
        for (int m = 0; m < 2; m++) begin
            sz = q[m].size();
            check($sformatf("%s_m%0d_head", ph, m), 32'(sel_resp[m]), (sz != 0) ? q[m][0] : 6);
            check($sformatf("%s_m%0d_valid", ph, m), 32'(route_valid[m]), int'(sz != 0));
            check($sformatf("%s_m%0d_stall", ph, m), 32'(stall[m]), int'(sz == depth_of(m)));
            check($sformatf("%s_m%0d_count", ph, m), 32'(outstanding[m]), sz);
            check($sformatf("%s_m%0d_ovf", ph, m), 32'(ovf_err[m]), int'(m_ovf[m]));
            check($sformatf("%s_m%0d_unf", ph, m), 32'(unf_err[m]), int'(m_unf[m]));
        end
    endtask

    task automatic cycle(input logic [6:0] v, input logic ah, input logic rh, input logic rl,
                         input string ph);
        @(negedge ACLK);
        valid = v; addr_hs = ah; resp_hs = rh; resp_last = rl;
        #1;
        check({ph, "_dec_r"}, 32'(sel_addr[0]), decode(v));
        check({ph, "_dec_b"}, 32'(sel_addr[1]), decode(v));
        @(posedge ACLK);
        model_edge();
        #1;
        check_outputs(ph);
    endtask

    // Assert reset between clock edges and expect the reset state without any edge.
    task automatic pulse_reset(input string ph);
        @(negedge ACLK);
        valid = '0; addr_hs = 0; resp_hs = 0; resp_last = 0;
        #2;
        ARESETn = 1'b0;
        #1;
        model_clear();
        check_outputs(ph);
        @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    function automatic logic [6:0] rand_valid();
        logic [6:0] one = 7'd1;
        if ($urandom_range(0, 9) < 7) return one << $urandom_range(0, 6);
        return 7'($urandom);
    endfunction

    initial begin
        ARESETn = 1'b0;
        valid = '0; addr_hs = 0; resp_hs = 0; resp_last = 0;
        model_clear();
        #12;
        check_outputs("rst0");
        ARESETn = 1'b1;

        // Decode
        cycle(7'b0000100, 0, 0, 0, "dec_one");
        check("dec_slave2", 32'(sel_addr[0]), 2);
        cycle(7'b0000000, 0, 0, 0, "dec_zero");
        check("dec_none_default", 32'(sel_addr[0]), 6);
        cycle(7'b0000110, 0, 0, 0, "dec_multi");
        check("dec_multi_default", 32'(sel_addr[0]), 6);

        // In-order routing
        cycle(7'b0000010, 1, 0, 0, "push1");
        cycle(7'b0001000, 1, 0, 0, "push3");
        cycle(7'b0000001, 1, 0, 0, "push0");
        check("order_head1", 32'(sel_resp[0]), 1);
        cycle(7'b0, 0, 1, 0, "midbeat");
        check("midbeat_head1", 32'(sel_resp[0]), 1);
        cycle(7'b0, 0, 1, 1, "pop_a");
        check("order_head3", 32'(sel_resp[0]), 3);
        cycle(7'b0, 0, 1, 1, "pop_b");
        check("order_head0", 32'(sel_resp[0]), 0);
        cycle(7'b0, 0, 1, 1, "pop_c");
        check("drained_head6", 32'(sel_resp[0]), 6);
        check("drained_valid0", 32'(route_valid[0]), 0);

        // Full, stall and wrap
        pulse_reset("rst1");
        for (int i = 0; i < 4; i++) cycle(7'd1 << i, 1, 0, 0, "fill");
        check("full_stall", 32'(stall[0]), 1);
        check("full_count", 32'(outstanding[0]), 4);
        for (int i = 0; i < 10; i++)
            cycle(7'd1 << $urandom_range(0, 6), 1, 1, 1, "wrap");
        check("wrap_count4", 32'(outstanding[0]), 4);
        check("wrap_no_ovf", 32'(ovf_err[0]), 0);

        // Overflow and stickiness
        cycle(7'b0100000, 1, 0, 0, "ovf");
        check("ovf_flag", 32'(ovf_err[0]), 1);
        check("ovf_count4", 32'(outstanding[0]), 4);
        for (int i = 0; i < 3; i++) cycle(7'b0, 0, 0, 0, "ovf_hold");
        check("ovf_sticky", 32'(ovf_err[0]), 1);
        pulse_reset("rst2");

        // Underflow and single-beat pops on the B instance
        cycle(7'b0, 0, 1, 1, "unf");
        check("unf_flag", 32'(unf_err[0]), 1);
        check("unf_count0", 32'(outstanding[0]), 0);
        pulse_reset("rst3");
        cycle(7'b0000100, 1, 0, 0, "b_push_a");
        cycle(7'b0010000, 1, 0, 0, "b_push_b");
        cycle(7'b0, 0, 1, 0, "b_pop_a");
        check("b_count1", 32'(outstanding[1]), 1);
        check("b_head4", 32'(sel_resp[1]), 4);
        cycle(7'b0, 0, 1, 0, "b_pop_b");
        check("b_count0", 32'(outstanding[1]), 0);
        check("b_no_unf", 32'(unf_err[1]), 0);

        // Randomized traffic
        pulse_reset("rst4");
        for (int i = 0; i < 400; i++) begin
            if (i == 200) pulse_reset("rst_rand");
            cycle(rand_valid(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), "rand");
        end

        // Asynchronous reset with entries outstanding
        pulse_reset("rst5");
        for (int i = 0; i < 3; i++) cycle(7'd1 << (i + 1), 1, 0, 0, "pre_async");
        pulse_reset("async");
        check("async_count0", 32'(outstanding[0]), 0);
        cycle(7'b0100000, 1, 0, 0, "post_async");
        check("post_async_head5", 32'(sel_resp[0]), 5);
        check("post_async_head5_b", 32'(sel_resp[1]), 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_route_tracker.md
# axi_route_tracker

Parametrised routing tracker for one AXI channel pair (AR/R or AW/B) inside the interconnect. It decodes the one-hot slave-select vector during the address phase and records the chosen slave index in an in-order FIFO on each address handshake. It then routes the response channel from the FIFO head until the closing response handshake, so up to `Depth` transactions can be outstanding. Transactions are single-ID and in-order.

## Interface
Parameters:
- `SlaveCount`, default 7: number of slave ports, including the default slave.
- `SelSlaveCount`, default 3: width of a slave index; must satisfy `2**SelSlaveCount >= SlaveCount`.
- `Depth`, default 4: maximum outstanding transactions; must be ≥1; need not be a power of two.
- `DefaultSlaveIdx`, default `SlaveCount-1`: index used for empty-FIFO and bad decode.
- `LastMode`, default 1:
  - 1: pop on `RespHandShake & RespLast` (R channel).
  - 0: pop on every `RespHandShake` (B channel).

Ports (direction, width, meaning):
- `ACLK` in 1: the only clock.
- `ARESETn` in 1: asynchronous, active-low reset.
- `VALID_Slave` in `SlaveCount`: one-hot address decode.
- `AddrHandShake` in 1: AxVALID & AxREADY this cycle.
- `RespHandShake` in 1: xVALID & xREADY on the response channel.
- `RespLast` in 1: RLAST; ignored when `LastMode=0`.
- `sel_AddrSlave` out `SelSlaveCount`: combinational decoded index for the address phase.
- `sel_RespSlave` out `SelSlaveCount`: registered FIFO head index; `DefaultSlaveIdx` when empty.
- `RespRouteValid` out 1: FIFO non-empty.
- `AddrStall` out 1: FIFO full; the interconnect must deassert AxREADY while this is high.
- `Outstanding` out `$clog2(Depth+1)`: current FIFO occupancy.
- `OverflowErr` out 1: sticky error flag.
- `UnderflowErr` out 1: sticky error flag.

## Operation
Decode (combinational):
- `sel_AddrSlave` = index of the set bit when `VALID_Slave` has exactly one bit set.
- Zero bits or more than one bit set gives `DefaultSlaveIdx`.

Push and pop:
- push = `AddrHandShake`. Writes `sel_AddrSlave` at the write pointer.
- pop = `RespHandShake & (RespLast | ~LastMode)`, qualified by non-empty. Advances the read pointer.
- Pointers run 0..`Depth-1` and wrap to 0. Occupancy counter runs 0..`Depth`.

Simultaneous events:
- push + pop, non-empty, not full: occupancy unchanged; both pointers advance.
- push + pop while full: push accepted, no overflow; occupancy stays `Depth`.
- push while empty with `RespHandShake`: the pop is ignored and `UnderflowErr` is set. The push is accepted.

Errors:
- push while full without pop: entry discarded, pointers and count unchanged, `OverflowErr` ← 1.
- pop condition while empty: no state change, `UnderflowErr` ← 1.
- Both flags are cleared only by reset.

Other rules:
- `RespHandShake` with `RespLast=0` in `LastMode=1` (mid-burst beat): no state change.
- `AddrStall = (Outstanding == Depth)`. `RespRouteValid = (Outstanding != 0)`.
- `sel_RespSlave` always equals the entry at the read pointer when non-empty, otherwise `DefaultSlaveIdx`.

## Timing
- Reset (asynchronous, `ARESETn` low), effective immediately:
  - pointers = 0, `Outstanding` = 0
  - `sel_RespSlave` = `DefaultSlaveIdx`
  - `RespRouteValid` = 0, `AddrStall` = 0
  - `OverflowErr` = 0, `UnderflowErr` = 0
  - FIFO contents don't-care.
- Reset mid-transaction drops all outstanding entries; no error flags are set.
- `sel_AddrSlave` has zero latency (combinational from `VALID_Slave`).
- Push at edge N: entry visible on `sel_RespSlave` and `RespRouteValid` after edge N if the FIFO was empty. A response can therefore be routed starting the cycle after the address handshake.
- Pop at edge N: the next entry, or `DefaultSlaveIdx` if now empty, is presented after edge N.
- `Outstanding`, `AddrStall` and `RespRouteValid` are all registered or derived from registers; they update after the same edge.
- No combinational path from `RespHandShake` or `AddrHandShake` to any output.

## Test plan
- **Reset and decode.** After reset, drive `VALID_Slave`=7'b0000100 → `sel_AddrSlave`=2. Drive 7'b0000000 or 7'b0000110 → `sel_AddrSlave`=6. Check `sel_RespSlave`=6, `RespRouteValid`=0, `Outstanding`=0.
- **In-order routing (`Depth`=4, `LastMode`=1).** Push slaves 1, 3, 0. Then `sel_RespSlave`=1. A beat with `RespLast`=0 leaves it at 1. A beat with `RespLast`=1 gives 3, then 0. After the last pop, `sel_RespSlave`=6 and `RespRouteValid`=0.
- **Full, stall and wrap.** Push 4 entries → `AddrStall`=1, `Outstanding`=4. Push + pop in the same cycle → count stays 4, no `OverflowErr`. Continue 10 push/pop cycles across pointer wrap → order preserved.
- **Overflow.** While full, push with no pop → `OverflowErr`=1, count 4, head unchanged. Flag persists until `ARESETn` is pulsed low.
- **Underflow and `LastMode`=0.** While empty, assert `RespHandShake` → `UnderflowErr`=1, count 0. With `LastMode`=0, push 2 → each single `RespHandShake` pops one entry.
- **Async reset mid-flight.** With 3 entries outstanding, drop `ARESETn` between clock edges → outputs return to reset values immediately. A subsequent push of slave 5 → `sel_RespSlave`=5 after 1 edge.
